// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dac_pkg
// Description : Shared types and widths for the speech-synth to PWM-DAC
//               sample path. The PWM DAC takes its sample width from here.
// Contents    : SAMPLE_W, CNT_W, dac_feed_state_t, sat_inc()
// Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int SAMPLE_W = 8;    // signed audio sample width
    localparam int CNT_W    = 8;    // underrun counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MUTE = 2'd2
    } dac_feed_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : dac_feed_ctrl_if
// Description : Sample stream from the synthesiser plus the DAC read port.
// Signals     : s_data/s_valid/s_ready - push stream into the controller
//               dac_din/dac_ack        - sample to DAC and its latch pulse
// Modports    : master - synthesiser/DAC side, slave - dac_feed_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface dac_feed_ctrl_if;
    import dac_pkg::*;

    logic [SAMPLE_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] dac_din;
    logic                dac_ack;

    modport master (
        output s_data,
        output s_valid,
        output dac_ack,
        input  s_ready,
        input  dac_din
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  dac_ack,
        output s_ready,
        output dac_din
    );

endinterface : dac_feed_ctrl_if
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Small register FIFO with show-ahead head and flush.
// Ports       : clk, rst_an         - clock, async active-low reset
//               push_i, din_i       - write strobe and data
//               pop_i               - advance read pointer (caller ensures
//                                     the FIFO is not empty)
//               flush_i             - discard contents (wins over push/pop)
//               head_o              - oldest entry, valid when level_o != 0
//               level_o             - occupancy, 0..2**DEPTH_LOG2
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import dac_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_an,
    input  wire logic                  push_i,
    input  wire logic [SAMPLE_W-1:0]   din_i,
    input  wire logic                  pop_i,
    input  wire logic                  flush_i,
    output logic      [SAMPLE_W-1:0]   head_o,
    output logic      [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    // One extra MSB on each pointer separates full from empty.
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;

    generate
        if (DEPTH_LOG2 > 0) begin : g_idx_multi
            assign wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
            assign rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
        end else begin : g_idx_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_idx] <= din_i;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Modular difference of the two registered pointers.
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_idx];

endmodule : sample_fifo
`default_nettype wire

// File: rtl/dac_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_feed_ctrl
// Description : Sample scheduler between the speech synthesiser (push) and
//               the 8-bit PWM DAC (pull). Buffers, primes before playback,
//               answers each DAC ack with the next sample, handles mute and
//               underrun and counts underruns.
// Ports       : clk, rst_an      - clock, async active-low reset
//               bus (slave)      - s_data/s_valid/s_ready, dac_din/dac_ack
//               mute             - level-sensitive mute request
//               clr_cnt          - synchronous clear of underrun_cnt
//               level            - FIFO occupancy
//               underrun_cnt     - saturating underrun count
// Revision    : 1.0 - initial release
// ============================================================================
module dac_feed_ctrl
    import dac_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int PRIME_LEVEL = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_an,
    dac_feed_ctrl_if.slave          bus,
    input  wire logic               mute,
    input  wire logic               clr_cnt,
    output logic [DEPTH_LOG2:0]     level,
    output logic [CNT_W-1:0]        underrun_cnt
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] PRIME_LVL = PRIME_LEVEL[DEPTH_LOG2:0];

    dac_feed_state_t     state_q;
    logic [SAMPLE_W-1:0] dac_din_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic                ready;
    logic                push;
    logic                pop;
    logic                underrun;
    logic [SAMPLE_W-1:0] head;

    // Mute dominates: it blocks the push, the pop and the underrun count
    // in the same cycle it flushes the FIFO.
    always_comb begin
        ready    = (level != DEPTH_LVL) && !mute && (state_q != MUTE);
        push     = bus.s_valid && ready;
        pop      = !mute && (state_q == PLAY) && bus.dac_ack && (level != '0);
        underrun = !mute && (state_q == PLAY) && bus.dac_ack && (level == '0);
    end

    sample_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_an  (rst_an),
        .push_i  (push),
        .din_i   (bus.s_data),
        .pop_i   (pop),
        .flush_i (mute),
        .head_o  (head),
        .level_o (level)
    );

    // dac_din only moves on an ack, so the DAC never samples a changing bus.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q   <= IDLE;
            dac_din_q <= '0;
        end else if (mute) begin
            state_q <= MUTE;
            if (bus.dac_ack) dac_din_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.dac_ack) dac_din_q <= '0;
                    if (level >= PRIME_LVL) state_q <= PLAY;
                end
                PLAY: begin
                    if (bus.dac_ack) begin
                        if (level == '0) begin
                            // Starved: output silence and re-prime; a sample
                            // pushed in this cycle is kept, not bypassed.
                            dac_din_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            dac_din_q <= head;
                        end
                    end
                end
                MUTE: begin
                    if (bus.dac_ack) dac_din_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    dac_din_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (underrun) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.s_ready   = ready;
    assign bus.dac_din   = dac_din_q;
    assign underrun_cnt  = cnt_q;

endmodule : dac_feed_ctrl
`default_nettype wire

// File: tb/tb_dac_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_feed_ctrl
// Description : Self-checking bench for dac_feed_ctrl (DEPTH=4, PRIME=2).
//               A queue-based model predicts every output each cycle;
//               directed sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_feed_ctrl;

    localparam int DEPTH_LOG2  = 2;
    localparam int PRIME_LEVEL = 2;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic                  clk;
    logic                  rst_an;
    logic                  mute;
    logic                  clr_cnt;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            underrun_cnt;

    dac_feed_ctrl_if bus ();

    dac_feed_ctrl #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .PRIME_LEVEL (PRIME_LEVEL)
    ) dut (
        .clk          (clk),
        .rst_an       (rst_an),
        .bus          (bus),
        .mute         (mute),
        .clr_cnt      (clr_cnt),
        .level        (level),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting to prime, 1 playing, 2 muted
    logic [7:0] mq[$];
    int         mmode;
    logic [7:0] mdac;
    int         mcnt;

    initial begin
        int  sz;
        bit  ack, rdy, psh, inc;
        mq.delete(); mmode = 0; mdac = 8'h00; mcnt = 0;
        forever begin
            @(posedge clk or negedge rst_an);
            if (!rst_an) begin
                mq.delete(); mmode = 0; mdac = 8'h00; mcnt = 0;
            end else begin
                ack = bus.dac_ack;
                sz  = mq.size();
                rdy = (sz != DEPTH) && !mute && (mmode != 2);
                psh = bus.s_valid && rdy;
                inc = 1'b0;
                if (mute) begin
                    mq.delete();
                    mmode = 2;
                    if (ack) mdac = 8'h00;
                end else if (mmode == 2) begin
                    mmode = 0;
                    if (ack) mdac = 8'h00;
                end else if (mmode == 0) begin
                    if (ack) mdac = 8'h00;
                    if (psh) mq.push_back(bus.s_data);
                    if (sz >= PRIME_LEVEL) mmode = 1;
                end else begin
                    if (ack) begin
                        if (sz == 0) begin
                            mdac = 8'h00; inc = 1'b1; mmode = 0;
                        end else begin
                            mdac = mq.pop_front();
                        end
                    end
                    if (psh) mq.push_back(bus.s_data);
                end
                if (clr_cnt)                mcnt = 0;
                else if (inc && mcnt < 255) mcnt = mcnt + 1;
            end
        end
    end

    // Per-cycle comparison, half a period away from the active edge.
    always @(negedge clk) begin
        chk("m_dac_din", bus.dac_din, mdac);
        chk("m_level", level, mq.size());
        chk("m_underrun_cnt", underrun_cnt, mcnt);
        chk("m_s_ready", bus.s_ready,
            ((mq.size() != DEPTH) && !mute && (mmode != 2)) ? 1 : 0);
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ack_pulse();
        bus.dac_ack = 1'b1;
        tick();
        bus.dac_ack = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_an = 1'b0;
        tick();
        tick();
        rst_an = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_an = 1'b0; mute = 1'b0; clr_cnt = 1'b0;
        bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.dac_ack = 1'b0;
        #12;
        do_reset();

        // 1: acks with nothing buffered give silence
        repeat (3) ack_pulse();
        chk("t1_dac_din", bus.dac_din, 8'h00);
        chk("t1_s_ready", bus.s_ready, 1);
        chk("t1_level", level, 0);
        chk("t1_cnt", underrun_cnt, 0);

        // 2: prime then play
        push(8'h10);
        push(8'h20);
        chk("t2_level", level, 2);
        tick();
        ack_pulse();
        chk("t2_first", bus.dac_din, 8'h10);
        ack_pulse();
        chk("t2_second", bus.dac_din, 8'h20);

        // 3: underrun, then a lone push plus ack stays silent
        ack_pulse();
        chk("t3_dac_din", bus.dac_din, 8'h00);
        chk("t3_cnt", underrun_cnt, 1);
        bus.s_data = 8'h30; bus.s_valid = 1'b1; bus.dac_ack = 1'b1;
        tick();
        bus.s_valid = 1'b0; bus.dac_ack = 1'b0;
        chk("t3_unprimed", bus.dac_din, 8'h00);
        chk("t3_level", level, 1);

        // 4: fill to full, stall, free a slot
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("t4_full_level", level, 4);
        chk("t4_full_ready", bus.s_ready, 0);
        bus.s_data = 8'h05; bus.s_valid = 1'b1;
        tick();
        chk("t4_stall_level", level, 4);
        bus.dac_ack = 1'b1;
        tick();
        bus.dac_ack = 1'b0;
        chk("t4_pop", bus.dac_din, 8'h01);
        chk("t4_ready_back", bus.s_ready, 1);
        tick();
        bus.s_valid = 1'b0;
        chk("t4_accept", level, 4);
        for (int i = 2; i <= 5; i++) begin
            ack_pulse();
            chk("t4_order", bus.dac_din, i);
        end

        // 5: mute flushes, then re-prime is required
        do_reset();
        push(8'h41); push(8'h42); push(8'h43);
        ack_pulse();
        chk("t5_play", bus.dac_din, 8'h41);
        push(8'h44);
        chk("t5_level3", level, 3);
        mute = 1'b1;
        #1;
        chk("t5_ready_low", bus.s_ready, 0);
        tick();
        chk("t5_flushed", level, 0);
        ack_pulse();
        chk("t5_mute_ack", bus.dac_din, 8'h00);
        mute = 1'b0;
        tick();
        chk("t5_ready_back", bus.s_ready, 1);
        push(8'h50);
        ack_pulse();
        chk("t5_unprimed", bus.dac_din, 8'h00);
        push(8'h51);
        tick();
        ack_pulse();
        chk("t5_replay", bus.dac_din, 8'h50);

        // 6: counter saturation, clear precedence, async reset
        do_reset();
        for (int r = 0; r < 300; r++) begin
            push(8'hAA); push(8'hBB); tick();
            ack_pulse(); ack_pulse(); ack_pulse();
        end
        chk("t6_saturated", underrun_cnt, 255);
        push(8'hAA); push(8'hBB); tick();
        ack_pulse(); ack_pulse();
        clr_cnt = 1'b1;
        ack_pulse();
        clr_cnt = 1'b0;
        chk("t6_clear_wins", underrun_cnt, 0);
        push(8'hAA); push(8'hBB); tick();
        ack_pulse(); ack_pulse(); ack_pulse();
        chk("t6_count_again", underrun_cnt, 1);
        push(8'h5A); push(8'h6B); tick();
        ack_pulse();
        chk("t6_pre_reset", bus.dac_din, 8'h5A);
        bus.s_data = 8'h7C; bus.s_valid = 1'b1;
        #1;
        rst_an = 1'b0;
        #1;
        chk("t6_rst_dac", bus.dac_din, 8'h00);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_cnt", underrun_cnt, 0);
        tick();
        bus.s_valid = 1'b0;
        rst_an = 1'b1;
        tick();
        chk("t6_after_level", level, 0);
        chk("t6_after_ready", bus.s_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dac_feed_ctrl
`default_nettype wire
